branch_rs_scheduler: RTL and testbench

- Reservation station and issue scheduler for the single branch/jump functional unit.
- Buffers dispatched branch, JAL and JALR ops until both operands are valid, snooping the common data bus (CDB) for operand wake-up.
- Issues the oldest ready op, one per cycle, into a registered issue stage that drives the branch ALU inputs.
- Flushes its whole contents on a pipeline redirect.

---
 rtl/branch_rs_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_branch_rs_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_rs_scheduler.sv
// branch_rs_scheduler: reservation station and oldest-ready issue scheduler
// for the single branch/jump unit. Operands wake up by snooping the CDB.
// Optional feature macro: BRS_FASTPATH_EN. When it is defined, a dispatch with
// both operands ready goes straight to the issue register when the station has
// no candidate.
module branch_rs_scheduler #(
   parameter int WIDTH   = 31,
   parameter int C_WIDTH = 7,
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    disp_valid,
   output logic                    disp_ready,
   input  logic [WIDTH:0]          disp_src1,
   input  logic [WIDTH:0]          disp_src2,
   input  logic                    disp_src1_rdy,
   input  logic                    disp_src2_rdy,
   input  logic [TAG_W:0]          disp_src1_tag,
   input  logic [TAG_W:0]          disp_src2_tag,
   input  logic [C_WIDTH:0]        disp_ctrl,
   input  logic [WIDTH:0]          disp_pred_pc,
   input  logic [WIDTH:0]          disp_target,
   input  logic [TAG_W:0]          disp_rob_tag,
   input  logic                    cdb_valid,
   input  logic [TAG_W:0]          cdb_tag,
   input  logic [WIDTH:0]          cdb_data,
   output logic                    iss_valid,
   input  logic                    iss_ready,
   output logic [WIDTH:0]          iss_src1,
   output logic [WIDTH:0]          iss_src2,
   output logic [WIDTH:0]          iss_pred_pc,
   output logic [WIDTH:0]          iss_target,
   output logic [C_WIDTH:0]        iss_ctrl,
   output logic [TAG_W:0]          iss_rob_tag,
   output logic [$clog2(DEPTH):0]  occupancy
);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   // Station entries; age_q[i][j]=1 means entry j is older than entry i.
   logic [DEPTH-1:0] valid_q, s1_rdy_q, s2_rdy_q;
   logic [DEPTH-1:0] age_q [DEPTH];
   logic [WIDTH:0]   src1_q [DEPTH];
   logic [WIDTH:0]   src2_q [DEPTH];
   logic [WIDTH:0]   pc_q   [DEPTH];
   logic [WIDTH:0]   tgt_q  [DEPTH];
   logic [TAG_W:0]   tag1_q [DEPTH];
   logic [TAG_W:0]   tag2_q [DEPTH];
   logic [TAG_W:0]   rob_q  [DEPTH];
   logic [C_WIDTH:0] ctrl_q [DEPTH];

   logic [OCC_W-1:0] occupancy_q, occupancy_d;
   logic             iss_valid_q, iss_valid_d;
   logic [WIDTH:0]   iss_src1_q, iss_src1_d, iss_src2_q, iss_src2_d;
   logic [WIDTH:0]   iss_pc_q, iss_pc_d, iss_tgt_q, iss_tgt_d;
   logic [C_WIDTH:0] iss_ctrl_q, iss_ctrl_d;
   logic [TAG_W:0]   iss_rob_q, iss_rob_d;

   logic             cap1_s, cap2_s, d1_rdy_s, d2_rdy_s;
   logic [WIDTH:0]   d1_val_s, d2_val_s;
   logic             disp_fire_s, fast_s, alloc_s, iss_open_s, issue_load_s, any_cand_s;
   logic [DEPTH-1:0] cand_s, free_s, alloc_oh_s, sel_oh_s;
   logic [WIDTH:0]   sel_src1_s, sel_src2_s, sel_pc_s, sel_tgt_s;
   logic [C_WIDTH:0] sel_ctrl_s;
   logic [TAG_W:0]   sel_rob_s;

   // Full is judged on registered occupancy only, so a same-edge issue does not reopen it.
   assign disp_ready   = (occupancy_q != OCC_W'(DEPTH));
   assign cap1_s       = !disp_src1_rdy && cdb_valid && (cdb_tag == disp_src1_tag);
   assign cap2_s       = !disp_src2_rdy && cdb_valid && (cdb_tag == disp_src2_tag);
   assign d1_rdy_s     = disp_src1_rdy | cap1_s;
   assign d2_rdy_s     = disp_src2_rdy | cap2_s;
   assign d1_val_s     = cap1_s ? cdb_data : disp_src1;
   assign d2_val_s     = cap2_s ? cdb_data : disp_src2;
   assign disp_fire_s  = disp_valid & disp_ready & ~flush;
   assign cand_s       = valid_q & s1_rdy_q & s2_rdy_q;
   assign any_cand_s   = |cand_s;
   assign iss_open_s   = ~iss_valid_q | iss_ready;
   assign issue_load_s = iss_open_s & any_cand_s & ~flush;
`ifdef BRS_FASTPATH_EN
   assign fast_s       = disp_fire_s & d1_rdy_s & d2_rdy_s & iss_open_s & ~any_cand_s;
`else
   assign fast_s       = 1'b0;
`endif
   assign alloc_s      = disp_fire_s & ~fast_s;
   assign free_s       = ~valid_q;
   assign alloc_oh_s   = alloc_s ? (free_s & (~free_s + {{(DEPTH-1){1'b0}}, 1'b1}))
                                 : {DEPTH{1'b0}};

   // Oldest-ready select: a candidate wins when no older entry is also a candidate.
   always_comb begin
      sel_oh_s   = {DEPTH{1'b0}};
      sel_src1_s = {(WIDTH+1){1'b0}};
      sel_src2_s = {(WIDTH+1){1'b0}};
      sel_pc_s   = {(WIDTH+1){1'b0}};
      sel_tgt_s  = {(WIDTH+1){1'b0}};
      sel_ctrl_s = {(C_WIDTH+1){1'b0}};
      sel_rob_s  = {(TAG_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         sel_oh_s[i] = cand_s[i] & ((cand_s & age_q[i]) == {DEPTH{1'b0}});
         sel_src1_s  = sel_src1_s | ({(WIDTH+1){sel_oh_s[i]}} & src1_q[i]);
         sel_src2_s  = sel_src2_s | ({(WIDTH+1){sel_oh_s[i]}} & src2_q[i]);
         sel_pc_s    = sel_pc_s   | ({(WIDTH+1){sel_oh_s[i]}} & pc_q[i]);
         sel_tgt_s   = sel_tgt_s  | ({(WIDTH+1){sel_oh_s[i]}} & tgt_q[i]);
         sel_ctrl_s  = sel_ctrl_s | ({(C_WIDTH+1){sel_oh_s[i]}} & ctrl_q[i]);
         sel_rob_s   = sel_rob_s  | ({(TAG_W+1){sel_oh_s[i]}} & rob_q[i]);
      end
   end

   // Issue-stage and occupancy next state; flush overrides every load.
   always_comb begin
      iss_valid_d = iss_valid_q;
      iss_src1_d  = iss_src1_q;
      iss_src2_d  = iss_src2_q;
      iss_pc_d    = iss_pc_q;
      iss_tgt_d   = iss_tgt_q;
      iss_ctrl_d  = iss_ctrl_q;
      iss_rob_d   = iss_rob_q;
      occupancy_d = occupancy_q;
      if (flush) begin
         iss_valid_d = 1'b0;
         occupancy_d = {OCC_W{1'b0}};
      end else begin
         if (issue_load_s) begin
            iss_valid_d = 1'b1;
            iss_src1_d  = sel_src1_s;
            iss_src2_d  = sel_src2_s;
            iss_pc_d    = sel_pc_s;
            iss_tgt_d   = sel_tgt_s;
            iss_ctrl_d  = sel_ctrl_s;
            iss_rob_d   = sel_rob_s;
         end else if (fast_s) begin
            iss_valid_d = 1'b1;
            iss_src1_d  = d1_val_s;
            iss_src2_d  = d2_val_s;
            iss_pc_d    = disp_pred_pc;
            iss_tgt_d   = disp_target;
            iss_ctrl_d  = disp_ctrl;
            iss_rob_d   = disp_rob_tag;
         end else if (iss_ready) begin
            iss_valid_d = 1'b0;
         end else begin
            iss_valid_d = iss_valid_q;
         end
         case ({alloc_s, issue_load_s})
            2'b10:   occupancy_d = occupancy_q + {{(OCC_W-1){1'b0}}, 1'b1};
            2'b01:   occupancy_d = occupancy_q - {{(OCC_W-1){1'b0}}, 1'b1};
            default: occupancy_d = occupancy_q;
         endcase
      end
   end

   // Entry allocation, CDB wake-up, freeing on issue and age-matrix upkeep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= {DEPTH{1'b0}};
         s1_rdy_q <= {DEPTH{1'b0}};
         s2_rdy_q <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            age_q[i]  <= {DEPTH{1'b0}};
            src1_q[i] <= {(WIDTH+1){1'b0}};
            src2_q[i] <= {(WIDTH+1){1'b0}};
            pc_q[i]   <= {(WIDTH+1){1'b0}};
            tgt_q[i]  <= {(WIDTH+1){1'b0}};
            tag1_q[i] <= {(TAG_W+1){1'b0}};
            tag2_q[i] <= {(TAG_W+1){1'b0}};
            rob_q[i]  <= {(TAG_W+1){1'b0}};
            ctrl_q[i] <= {(C_WIDTH+1){1'b0}};
         end
      end else if (flush) begin
         valid_q <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            age_q[i] <= {DEPTH{1'b0}};
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc_oh_s[i]) begin
               valid_q[i]  <= 1'b1;
               age_q[i]    <= valid_q;
               s1_rdy_q[i] <= d1_rdy_s;
               s2_rdy_q[i] <= d2_rdy_s;
               src1_q[i]   <= d1_val_s;
               src2_q[i]   <= d2_val_s;
               tag1_q[i]   <= disp_src1_tag;
               tag2_q[i]   <= disp_src2_tag;
               pc_q[i]     <= disp_pred_pc;
               tgt_q[i]    <= disp_target;
               rob_q[i]    <= disp_rob_tag;
               ctrl_q[i]   <= disp_ctrl;
            end else begin
               // A new entry is never older than an existing one.
               age_q[i] <= age_q[i] & ~alloc_oh_s;
               if (issue_load_s && sel_oh_s[i]) begin
                  valid_q[i] <= 1'b0;
               end else begin
                  valid_q[i] <= valid_q[i];
               end
               if (valid_q[i] && !s1_rdy_q[i] && cdb_valid && (cdb_tag == tag1_q[i])) begin
                  s1_rdy_q[i] <= 1'b1;
                  src1_q[i]   <= cdb_data;
               end else begin
                  s1_rdy_q[i] <= s1_rdy_q[i];
               end
               if (valid_q[i] && !s2_rdy_q[i] && cdb_valid && (cdb_tag == tag2_q[i])) begin
                  s2_rdy_q[i] <= 1'b1;
                  src2_q[i]   <= cdb_data;
               end else begin
                  s2_rdy_q[i] <= s2_rdy_q[i];
               end
            end
         end
      end
   end

   // Issue register and occupancy counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_valid_q <= 1'b0;
         iss_src1_q  <= {(WIDTH+1){1'b0}};
         iss_src2_q  <= {(WIDTH+1){1'b0}};
         iss_pc_q    <= {(WIDTH+1){1'b0}};
         iss_tgt_q   <= {(WIDTH+1){1'b0}};
         iss_ctrl_q  <= {(C_WIDTH+1){1'b0}};
         iss_rob_q   <= {(TAG_W+1){1'b0}};
         occupancy_q <= {OCC_W{1'b0}};
      end else begin
         iss_valid_q <= iss_valid_d;
         iss_src1_q  <= iss_src1_d;
         iss_src2_q  <= iss_src2_d;
         iss_pc_q    <= iss_pc_d;
         iss_tgt_q   <= iss_tgt_d;
         iss_ctrl_q  <= iss_ctrl_d;
         iss_rob_q   <= iss_rob_d;
         occupancy_q <= occupancy_d;
      end
   end

   assign iss_valid   = iss_valid_q;
   assign iss_src1    = iss_src1_q;
   assign iss_src2    = iss_src2_q;
   assign iss_pred_pc = iss_pc_q;
   assign iss_target  = iss_tgt_q;
   assign iss_ctrl    = iss_ctrl_q;
   assign iss_rob_tag = iss_rob_q;
   assign occupancy   = occupancy_q;
endmodule

// File: tb/tb_branch_rs_scheduler.sv
// Scoreboard bench for branch_rs_scheduler: expected issues are queued at
// dispatch time and compared when the issue handshake completes.
module tb_branch_rs_scheduler;
   logic        clk = 1'b0;
   logic        rst_n, flush, disp_valid, disp_ready;
   logic [31:0] disp_src1, disp_src2, disp_pred_pc, disp_target, cdb_data;
   logic        disp_src1_rdy, disp_src2_rdy, cdb_valid, iss_valid, iss_ready;
   logic [3:0]  disp_src1_tag, disp_src2_tag, disp_rob_tag, cdb_tag, iss_rob_tag;
   logic [7:0]  disp_ctrl, iss_ctrl;
   logic [31:0] iss_src1, iss_src2, iss_pred_pc, iss_target;
   logic [2:0]  occupancy;

   typedef struct {
      logic [3:0]  rob;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [7:0]  ctrl;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   lat;

   always #5 clk = ~clk;

   branch_rs_scheduler dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_src1(disp_src1), .disp_src2(disp_src2),
      .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
      .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
      .disp_ctrl(disp_ctrl), .disp_pred_pc(disp_pred_pc), .disp_target(disp_target),
      .disp_rob_tag(disp_rob_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_pred_pc(iss_pred_pc),
      .iss_target(iss_target), .iss_ctrl(iss_ctrl), .iss_rob_tag(iss_rob_tag),
      .occupancy(occupancy)
   );

   // Scoreboard comparator: every accepted issue must match the queue head.
   always @(negedge clk) begin
      if (rst_n && iss_valid && iss_ready) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: got rob %0d, required no issue", iss_rob_tag);
         end else begin
            mon_e = sb_q.pop_front();
            if (iss_rob_tag !== mon_e.rob || iss_src1 !== mon_e.s1 || iss_src2 !== mon_e.s2 ||
                iss_ctrl !== mon_e.ctrl || iss_pred_pc !== (32'h2000 + {28'h0, mon_e.rob}) ||
                iss_target !== (32'h1000 + {28'h0, mon_e.rob})) begin
               n_fail++;
               $display("FAIL issue_data: got rob %0d s1 %h s2 %h ctrl %h pc %h tgt %h, required rob %0d s1 %h s2 %h ctrl %h",
                        iss_rob_tag, iss_src1, iss_src2, iss_ctrl, iss_pred_pc, iss_target,
                        mon_e.rob, mon_e.s1, mon_e.s2, mon_e.ctrl);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [3:0] rob, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [7:0] ctrl);
      exp_t e;
      e.rob = rob; e.s1 = s1; e.s2 = s2; e.ctrl = ctrl;
      sb_q.push_back(e);
   endtask

   // Presents one dispatch for one edge, then withdraws it.
   task automatic dispatch(input logic [31:0] s1, input logic r1, input logic [3:0] t1,
                           input logic [31:0] s2, input logic r2, input logic [3:0] t2,
                           input logic [7:0] ctrl, input logic [3:0] rob);
      disp_valid = 1'b1;
      disp_src1 = s1; disp_src1_rdy = r1; disp_src1_tag = t1;
      disp_src2 = s2; disp_src2_rdy = r2; disp_src2_tag = t2;
      disp_ctrl = ctrl; disp_rob_tag = rob;
      disp_pred_pc = 32'h2000 + {28'h0, rob};
      disp_target  = 32'h1000 + {28'h0, rob};
      step();
      disp_valid = 1'b0;
   endtask

   task automatic cdb_pulse(input logic [3:0] tag, input logic [31:0] data);
      cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
      step();
      cdb_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int c = 0; c < 50 && sb_q.size() != 0; c++) step();
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d issues still pending, required 0", name, sb_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0; cdb_valid = 1'b0;
      cdb_tag = 4'h0; cdb_data = 32'h0;
      disp_src1 = 32'h0; disp_src2 = 32'h0; disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
      disp_src1_tag = 4'h0; disp_src2_tag = 4'h0; disp_ctrl = 8'h0; disp_rob_tag = 4'h0;
      disp_pred_pc = 32'h0; disp_target = 32'h0;
      #12;
      n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid: got %b, required 0", iss_valid); end
      n_tests++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d, required 0", occupancy); end
      n_tests++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready: got %b, required 1", disp_ready); end
      n_tests++;
      if ((iss_src1 | iss_src2 | iss_pred_pc | iss_target) !== 32'h0 || iss_ctrl !== 8'h0 || iss_rob_tag !== 4'h0) begin
         n_fail++; $display("FAIL reset_iss_data: got src1 %h src2 %h, required all zero", iss_src1, iss_src2);
      end
      @(negedge clk); rst_n = 1'b1;
      step();
   endtask

   // Both operands ready at dispatch: issue latency and drain back to empty.
   task automatic test_latency(input string name, input logic [31:0] s1, input logic [31:0] s2,
                               input logic [7:0] ctrl, input logic [3:0] rob);
      iss_ready = 1'b1;
      push_exp(rob, s1, s2, ctrl);
      dispatch(s1, 1'b1, 4'h0, s2, 1'b1, 4'h0, ctrl, rob);
      for (int c = 1; c < lat; c++) begin
         n_tests++; if (iss_valid !== 1'b0 || occupancy !== 3'd1) begin
            n_fail++; $display("FAIL %s_early: got valid %b occ %0d, required 0 and 1", name, iss_valid, occupancy); end
         step();
      end
      n_tests++;
      if (iss_valid !== 1'b1 || iss_src1 !== s1 || iss_src2 !== s2) begin
         n_fail++; $display("FAIL %s_latency: got valid %b src1 %h src2 %h, required 1 %h %h", name, iss_valid, iss_src1, iss_src2, s1, s2);
      end
      n_tests++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL %s_occ: got %0d, required 0", name, occupancy); end
      step();
      n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL %s_empty_drop: got %b, required 0", name, iss_valid); end
   endtask

   task automatic test_wakeup_order();
      iss_ready = 1'b1;
      push_exp(4'd3, 32'h7, 32'h8, 8'h05);
      push_exp(4'd2, 32'h1, 32'h10, 8'h0C);
      dispatch(32'h1, 1'b1, 4'h0, 32'h0, 1'b0, 4'd3, 8'h0C, 4'd2);
      dispatch(32'h7, 1'b1, 4'h0, 32'h8, 1'b1, 4'h0, 8'h05, 4'd3);
      step(); step(); step();
      n_tests++; if (iss_valid !== 1'b0 || occupancy !== 3'd1) begin
         n_fail++; $display("FAIL wake_waiting: got valid %b occ %0d, required 0 and 1", iss_valid, occupancy); end
      cdb_pulse(4'd3, 32'h10);
      n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL wake_too_early: got %b, required 0", iss_valid); end
      step();
      n_tests++; if (iss_valid !== 1'b1 || iss_rob_tag !== 4'd2) begin
         n_fail++; $display("FAIL wake_latency: got valid %b rob %0d, required 1 and 2", iss_valid, iss_rob_tag); end
      step();
      // Dispatch-cycle capture of a broadcast for a not-ready source.
      push_exp(4'd4, 32'h55, 32'h66, 8'h06);
      cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'h55;
      dispatch(32'hDEAD, 1'b0, 4'd5, 32'h66, 1'b1, 4'h0, 8'h06, 4'd4);
      cdb_valid = 1'b0;
      wait_drain("capture");
      step();
   endtask

   task automatic test_full();
      iss_ready = 1'b1;
      for (int i = 0; i < 4; i++)
         dispatch(32'h0, 1'b0, 4'd2, 32'h100 + i, 1'b1, 4'h0, 8'h01, 4'(8 + i));
      n_tests++; if (occupancy !== 3'd4 || disp_ready !== 1'b0) begin
         n_fail++; $display("FAIL full_state: got occ %0d ready %b, required 4 and 0", occupancy, disp_ready); end
      dispatch(32'h0, 1'b1, 4'h0, 32'h0, 1'b1, 4'h0, 8'h01, 4'd15);
      n_tests++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL full_reject: got occ %0d, required 4", occupancy); end
      for (int i = 0; i < 4; i++) push_exp(4'(8 + i), 32'h22, 32'h100 + i, 8'h01);
      cdb_pulse(4'd2, 32'h22);
      n_tests++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_during_issue: got %b, required 0", disp_ready); end
      for (int c = 0; c < 4; c++) begin
         step();
         n_tests++;
         if (iss_valid !== 1'b1 || iss_rob_tag !== 4'(8 + c) || occupancy !== 3'(3 - c)) begin
            n_fail++; $display("FAIL full_consecutive_%0d: got valid %b rob %0d occ %0d, required 1 %0d %0d",
                               c, iss_valid, iss_rob_tag, occupancy, 8 + c, 3 - c);
         end
      end
      step();
      n_tests++; if (iss_valid !== 1'b0 || disp_ready !== 1'b1) begin
         n_fail++; $display("FAIL full_drained: got valid %b ready %b, required 0 and 1", iss_valid, disp_ready); end
   endtask

   task automatic test_backpressure();
      iss_ready = 1'b0;
      push_exp(4'd1, 32'hA1, 32'hA2, 8'h04);
      push_exp(4'd5, 32'hB1, 32'hB2, 8'h14);
      dispatch(32'hA1, 1'b1, 4'h0, 32'hA2, 1'b1, 4'h0, 8'h04, 4'd1);
      dispatch(32'hB1, 1'b1, 4'h0, 32'hB2, 1'b1, 4'h0, 8'h14, 4'd5);
      step();
      for (int c = 0; c < 3; c++) begin
         n_tests++;
         if (iss_valid !== 1'b1 || iss_rob_tag !== 4'd1 || iss_src1 !== 32'hA1 || iss_src2 !== 32'hA2 || occupancy !== 3'd1) begin
            n_fail++; $display("FAIL hold_stable_%0d: got valid %b rob %0d src1 %h occ %0d, required 1 1 a1 1",
                               c, iss_valid, iss_rob_tag, iss_src1, occupancy);
         end
         step();
      end
      iss_ready = 1'b1;
      step();
      n_tests++; if (iss_valid !== 1'b1 || iss_rob_tag !== 4'd5) begin
         n_fail++; $display("FAIL hold_next: got valid %b rob %0d, required 1 and 5", iss_valid, iss_rob_tag); end
      step();
      n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL hold_drop: got %b, required 0", iss_valid); end
   endtask

   task automatic test_flush();
      iss_ready = 1'b0;
      dispatch(32'h3, 1'b1, 4'h0, 32'h4, 1'b1, 4'h0, 8'h04, 4'd1);
      for (int i = 0; i < 3; i++) dispatch(32'h0, 1'b0, 4'd6, 32'h9, 1'b1, 4'h0, 8'h01, 4'(2 + i));
      step();
      n_tests++; if (iss_valid !== 1'b1 || occupancy !== 3'd3) begin
         n_fail++; $display("FAIL flush_pre: got valid %b occ %0d, required 1 and 3", iss_valid, occupancy); end
      flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_data = 32'h66;
      dispatch(32'h1, 1'b1, 4'h0, 32'h2, 1'b1, 4'h0, 8'h04, 4'd7);
      flush = 1'b0; cdb_valid = 1'b0;
      n_tests++; if (iss_valid !== 1'b0 || occupancy !== 3'd0 || disp_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_clear: got valid %b occ %0d ready %b, required 0 0 1", iss_valid, occupancy, disp_ready); end
      iss_ready = 1'b1;
      cdb_pulse(4'd6, 32'h66);
      for (int c = 0; c < 4; c++) step();
      n_tests++; if (iss_valid !== 1'b0 || occupancy !== 3'd0) begin
         n_fail++; $display("FAIL flush_absent: got valid %b occ %0d, required 0 and 0", iss_valid, occupancy); end
   endtask

   task automatic test_async_reset();
      iss_ready = 1'b0;
      dispatch(32'h3, 1'b1, 4'h0, 32'h4, 1'b1, 4'h0, 8'h04, 4'd3);
      dispatch(32'h5, 1'b1, 4'h0, 32'h6, 1'b1, 4'h0, 8'h04, 4'd4);
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (iss_valid !== 1'b0 || occupancy !== 3'd0) begin
         n_fail++; $display("FAIL async_reset: got valid %b occ %0d, required 0 and 0", iss_valid, occupancy); end
      @(negedge clk); rst_n = 1'b1;
      step();
   endtask

   initial begin
`ifdef BRS_FASTPATH_EN
      lat = 1;
`else
      lat = 2;
`endif
      test_reset();
      test_latency("beq", 32'h5, 32'h5, 8'b00000100, 4'd1);
      test_latency("jalr", 32'h40, 32'h0, 8'b01000000, 4'd6);
      test_wakeup_order();
      test_full();
      test_backpressure();
      test_flush();
      test_async_reset();
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_empty: %0d left, required 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end
endmodule
